// File: rtl/cnn_obuf_writer.sv
// cnn_obuf_writer: requantizes PE-array accumulator vectors lane by lane (rounding arithmetic
// right shift), queues the packed results in a small FIFO and writes them to the output SRAM
// whenever the memory port is granted. A run covers num_words vectors starting at base_addr.
// Optional feature macro: QUANT_SAT_EN (clamp each lane to the signed output range and count
// clamped lanes in sat_cnt). Without it, lanes use legacy sign-plus-low-bits packing.
module cnn_obuf_writer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned ACCU_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SHIFT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        num_words,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*ACCU_WIDTH-1:0] in_data,
  input  logic                         mem_grant,
  output logic                         mem_wen_n,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [NUM_CH*OUT_WIDTH-1:0]  mem_data,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  sat_cnt
);

  localparam int unsigned InW  = NUM_CH * ACCU_WIDTH;
  localparam int unsigned OutW = NUM_CH * OUT_WIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  // One extra bit so the rounding add cannot overflow.
  localparam int unsigned VW   = ACCU_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   num_q, num_d;
  logic [ADDR_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_idx_q, wr_idx_d;
  logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic                    in_vld_q, in_vld_d;
  logic [InW-1:0]          in_data_q, in_data_d;
  logic                    q_vld_q, q_vld_d;
  logic [OutW-1:0]         q_data_q, q_data_d;
  logic [PtrW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]         fcnt_q, fcnt_d;
  logic [OutW-1:0]         fifo_mem_q [FIFO_DEPTH];
  logic                    wen_n_q, wen_n_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [OutW-1:0]         data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;

  logic [OutW-1:0]         quant_data;
  logic [15:0]             quant_nsat;
  logic signed [VW-1:0]    lane_v, lane_sh, rnd;
  logic                    unused_sh;
  logic [OccW-1:0]         occ;
  logic [16:0]             sat_sum;
  logic                    accept, pop, push, q_load, in_load, fifo_full;

`ifdef QUANT_SAT_EN
  localparam logic signed [VW-1:0] OutMax = (VW'(1) << (OUT_WIDTH - 1)) - VW'(1);
  localparam logic signed [VW-1:0] OutMin = -OutMax - VW'(1);
`endif

  // Per-lane requantization of the input register: round, arithmetic shift, then pack.
  always_comb begin
    quant_data = '0;
    quant_nsat = '0;
    lane_v     = '0;
    lane_sh    = '0;
    rnd        = '0;
    unused_sh  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_v  = {in_data_q[i*ACCU_WIDTH + ACCU_WIDTH - 1], in_data_q[i*ACCU_WIDTH +: ACCU_WIDTH]};
      rnd     = (shift_q != '0) ? (VW'(1) << (shift_q - 1'b1)) : '0;
      lane_v  = lane_v + rnd;
      lane_sh = lane_v >>> shift_q;
`ifdef QUANT_SAT_EN
      if (lane_sh > OutMax) begin
        quant_data[i*OUT_WIDTH +: OUT_WIDTH] = OutMax[OUT_WIDTH-1:0];
        quant_nsat = quant_nsat + 16'd1;
      end else if (lane_sh < OutMin) begin
        quant_data[i*OUT_WIDTH +: OUT_WIDTH] = OutMin[OUT_WIDTH-1:0];
        quant_nsat = quant_nsat + 16'd1;
      end else begin
        quant_data[i*OUT_WIDTH +: OUT_WIDTH] = lane_sh[OUT_WIDTH-1:0];
      end
`else
      quant_data[i*OUT_WIDTH +: OUT_WIDTH] = {lane_sh[VW-1], lane_sh[OUT_WIDTH-2:0]};
`endif
      unused_sh = unused_sh ^ (^lane_sh);
    end
  end

  // Ready is purely combinational from the occupancy so the FIFO can never overflow.
  assign occ       = {1'b0, fcnt_q} + {{CntW{1'b0}}, q_vld_q};
  assign in_ready  = (state_q == StRun) && enable && (acc_cnt_q < num_q) &&
                     (occ < OccW'(FIFO_DEPTH));
  assign fifo_full = (fcnt_q == CntW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign pop       = enable && mem_grant && (fcnt_q != '0);
  assign push      = enable && q_vld_q && (!fifo_full || pop);
  assign q_load    = enable && (!q_vld_q || push);
  assign in_load   = enable && (!in_vld_q || q_load);
  assign sat_sum   = {1'b0, sat_cnt_q} + {1'b0, quant_nsat};

  // Datapath next state: input reg -> quant reg -> FIFO -> output regs, plus run counters.
  always_comb begin
    in_vld_d  = in_load ? accept : in_vld_q;
    in_data_d = accept ? in_data : in_data_q;
    q_vld_d   = q_load ? in_vld_q : q_vld_q;
    q_data_d  = (q_load && in_vld_q) ? quant_data : q_data_q;
    sat_cnt_d = sat_cnt_q;
    if (q_load && in_vld_q) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
    acc_cnt_d = accept ? acc_cnt_q + 1'b1 : acc_cnt_q;
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    fcnt_d    = fcnt_q;
    if (push && !pop) begin
      fcnt_d = fcnt_q + 1'b1;
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - 1'b1;
    end
    // Write strobe lasts exactly one cycle per popped word and is never asserted while stalled.
    wen_n_d  = 1'b1;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_idx_d = wr_idx_q;
    if (pop) begin
      wen_n_d  = 1'b0;
      addr_d   = base_q + wr_idx_q;
      data_d   = fifo_mem_q[rptr_q];
      wr_idx_d = wr_idx_q + 1'b1;
    end

    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    shift_d = shift_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_d    = base_addr;
            num_d     = num_words;
            shift_d   = shift;
            acc_cnt_d = '0;
            wr_idx_d  = '0;
            sat_cnt_d = '0;
            state_d   = (num_words == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (acc_cnt_d == num_q) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          // The final pop has already loaded the output regs when everything upstream is empty.
          if (!in_vld_q && !q_vld_q && (fcnt_q == '0)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  // Control, pipeline and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      num_q     <= '0;
      acc_cnt_q <= '0;
      wr_idx_q  <= '0;
      shift_q   <= '0;
      in_vld_q  <= 1'b0;
      in_data_q <= '0;
      q_vld_q   <= 1'b0;
      q_data_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      wen_n_q   <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      acc_cnt_q <= acc_cnt_d;
      wr_idx_q  <= wr_idx_d;
      shift_q   <= shift_d;
      in_vld_q  <= in_vld_d;
      in_data_q <= in_data_d;
      q_vld_q   <= q_vld_d;
      q_data_q  <= q_data_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      wen_n_q   <= wen_n_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers and count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= q_data_q;
    end
  end

  assign mem_wen_n = wen_n_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
